// File: rtl/acc_sample_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : acc_sample_scheduler_pkg
// Brief    : Shared constants, FSM encoding and frame helpers for the
//            accelerometer sample scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package acc_sample_scheduler_pkg;

    localparam int         c_FRAME_LEN         = 8;
    localparam logic [7:0] c_SYNC_BYTE_DEFAULT = 8'hA5;

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_WAIT_TICK = 3'd1;
    localparam logic [2:0] c_ST_START     = 3'd2;
    localparam logic [2:0] c_ST_WAIT_READ = 3'd3;
    localparam logic [2:0] c_ST_LATCH     = 3'd4;
    localparam logic [2:0] c_ST_SEND      = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE      = c_ST_IDLE,
        ST_WAIT_TICK = c_ST_WAIT_TICK,
        ST_START     = c_ST_START,
        ST_WAIT_READ = c_ST_WAIT_READ,
        ST_LATCH     = c_ST_LATCH,
        ST_SEND      = c_ST_SEND
    } sched_state_t;

    // Checksum byte: XOR of the six payload bytes {x, y, z}, MSB first.
    function automatic logic [7:0] frame_checksum(input logic [47:0] sample);
        return sample[47:40] ^ sample[39:32] ^ sample[31:24] ^
               sample[23:16] ^ sample[15:8]  ^ sample[7:0];
    endfunction

    // A sample is "in flight" in every state except the two resting ones.
    function automatic logic state_is_busy(input sched_state_t st);
        return (st != ST_IDLE) && (st != ST_WAIT_TICK);
    endfunction

endpackage
`default_nettype wire

// File: rtl/acc_sample_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : acc_sample_scheduler_if
// Brief    : Reader-side and UART-side signals of the sample scheduler.
//            master = scheduler, slave = surrounding glove logic.
// Revision : 1.0 - initial release
// ============================================================================
interface acc_sample_scheduler_if;
    logic               enable;
    logic               done_init;
    logic               done_read;
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
    logic               rd_start;
    logic [7:0]         tx_data;
    logic               tx_valid;
    logic               tx_ready;
    logic               busy;
    logic [7:0]         overrun_cnt;
    logic               timeout;

    modport master (
        input  enable, done_init, done_read, x, y, z, tx_ready,
        output rd_start, tx_data, tx_valid, busy, overrun_cnt, timeout
    );

    modport slave (
        output enable, done_init, done_read, x, y, z, tx_ready,
        input  rd_start, tx_data, tx_valid, busy, overrun_cnt, timeout
    );
endinterface
`default_nettype wire

// File: rtl/acc_sample_scheduler_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : acc_frame_tx
// Brief    : Holds the latched x/y/z sample and streams the 8-byte frame
//            (sync, payload, checksum) over a valid/ready byte interface.
// Revision : 1.0 - initial release
// ============================================================================
module acc_frame_tx
    import acc_sample_scheduler_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = c_SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_capture,
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic [15:0] i_z,
    input  logic        i_load,
    input  logic        i_tx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    output logic        o_done
);
    localparam logic [2:0] c_LAST_IDX = 3'(c_FRAME_LEN - 1);

    logic [47:0] r_sample;
    logic [2:0]  r_idx;
    logic        r_valid;
    logic [7:0]  w_byte;
    logic        w_accept;

    assign w_accept = r_valid && i_tx_ready;

    // Sample latch, byte index and valid flag; index moves only on a handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sample <= '0;
            r_idx    <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (i_capture) begin
                r_sample <= {i_x, i_y, i_z};
            end
            if (i_load) begin
                r_idx   <= '0;
                r_valid <= 1'b1;
            end else if (w_accept) begin
                if (r_idx == c_LAST_IDX) begin
                    r_valid <= 1'b0;
                end else begin
                    r_idx <= r_idx + 3'd1;
                end
            end
        end
    end

    // Byte selection for the current frame position
    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            3'd0:    w_byte = SYNC_BYTE;
            3'd1:    w_byte = r_sample[47:40];
            3'd2:    w_byte = r_sample[39:32];
            3'd3:    w_byte = r_sample[31:24];
            3'd4:    w_byte = r_sample[23:16];
            3'd5:    w_byte = r_sample[15:8];
            3'd6:    w_byte = r_sample[7:0];
            default: w_byte = frame_checksum(r_sample);
        endcase
    end

    // Data is forced to zero whenever nothing is offered so reset leaves a clean bus
    assign o_tx_data  = r_valid ? w_byte : 8'h00;
    assign o_tx_valid = r_valid;
    assign o_done     = w_accept && (r_idx == c_LAST_IDX);

endmodule
`default_nettype wire

// File: rtl/acc_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : acc_sample_scheduler
// Brief    : Paces accelerometer reads, supervises each read with a timeout,
//            and forwards every completed sample as an 8-byte UART frame.
// Revision : 1.0 - initial release
// ============================================================================
module acc_sample_scheduler
    import acc_sample_scheduler_pkg::*;
#(
    parameter int         SAMPLE_DIV  = 1_000_000,
    parameter int         TIMEOUT_CYC = 200_000,
    parameter logic [7:0] SYNC_BYTE   = c_SYNC_BYTE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    acc_sample_scheduler_if.master bus
);
    localparam int c_CNT_W = $clog2(SAMPLE_DIV);
    localparam int c_TO_W  = $clog2(TIMEOUT_CYC);

    sched_state_t        r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_TO_W-1:0]   r_tcnt;
    logic                r_rd_start;
    logic                r_timeout;
    logic [7:0]          r_overrun;

    logic                w_run;
    logic                w_tick;
    logic [c_TO_W-1:0]   w_tcnt_nxt;
    logic                w_tcnt_expired;
    logic                w_capture;
    logic                w_load;
    logic                w_frame_done;
    logic [7:0]          w_tx_data;
    logic                w_tx_valid;

    assign w_run  = bus.enable && bus.done_init;
    assign w_tick = w_run && (r_cnt == c_CNT_W'(SAMPLE_DIV - 1));

    // Expiry is judged on the incremented value so the flag becomes visible
    // exactly TIMEOUT_CYC cycles after the rd_start pulse.
    assign w_tcnt_nxt     = r_tcnt + c_TO_W'(1);
    assign w_tcnt_expired = (w_tcnt_nxt == c_TO_W'(TIMEOUT_CYC - 1));

    assign w_capture = (r_state == ST_WAIT_READ) && bus.done_read;
    assign w_load    = (r_state == ST_LATCH);

    // Sample-period counter: runs only while sampling is permitted, else parked at 0
    always_ff @(posedge clk) begin
        if (rst || !w_run) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
        end
    end

    // Scheduler FSM with registered rd_start, read timeout and overrun accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_tcnt     <= '0;
            r_rd_start <= 1'b0;
            r_timeout  <= 1'b0;
            r_overrun  <= '0;
        end else begin
            r_rd_start <= 1'b0;

            // A tick that cannot start a read is dropped and only counted
            if (w_tick && (r_state != ST_WAIT_TICK) && (r_overrun != 8'hFF)) begin
                r_overrun <= r_overrun + 8'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_run) begin
                        r_state <= ST_WAIT_TICK;
                    end
                end
                ST_WAIT_TICK: begin
                    if (!bus.enable) begin
                        r_state <= ST_IDLE;
                    end else if (w_tick) begin
                        r_state    <= ST_START;
                        r_rd_start <= 1'b1;
                    end
                end
                ST_START: begin
                    r_tcnt  <= '0;
                    r_state <= ST_WAIT_READ;
                end
                ST_WAIT_READ: begin
                    if (bus.done_read) begin
                        r_state <= ST_LATCH;
                    end else if (w_tcnt_expired) begin
                        r_timeout <= 1'b1;
                        r_state   <= bus.enable ? ST_WAIT_TICK : ST_IDLE;
                    end else if (!bus.enable) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_tcnt <= w_tcnt_nxt;
                    end
                end
                ST_LATCH: begin
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    // A started frame always completes; enable only picks the exit
                    if (w_frame_done) begin
                        r_state <= bus.enable ? ST_WAIT_TICK : ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    acc_frame_tx #(
        .SYNC_BYTE (SYNC_BYTE)
    ) u_frame_tx (
        .clk        (clk),
        .rst        (rst),
        .i_capture  (w_capture),
        .i_x        (bus.x),
        .i_y        (bus.y),
        .i_z        (bus.z),
        .i_load     (w_load),
        .i_tx_ready (bus.tx_ready),
        .o_tx_data  (w_tx_data),
        .o_tx_valid (w_tx_valid),
        .o_done     (w_frame_done)
    );

    assign bus.rd_start    = r_rd_start;
    assign bus.tx_data     = w_tx_data;
    assign bus.tx_valid    = w_tx_valid;
    assign bus.busy        = state_is_busy(r_state);
    assign bus.overrun_cnt = r_overrun;
    assign bus.timeout     = r_timeout;

endmodule
`default_nettype wire
